// File: rtl/delay_ctrl_pkg.sv
// Shared constants, FSM state type and valid-bit counter for the delay_ctrl block.
// Optional feature macro: DELAY_CTRL_DROP_CNT_EN (drop counter output).
package delay_ctrl_pkg;

  localparam int MAX_DELAY = 16;
  localparam int DLY_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2
  } state_t;

  function automatic logic [4:0] count_valid(input logic [MAX_DELAY-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < MAX_DELAY; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/delay_ctrl_line.sv
// Free-running 16-stage {valid, data} shift chain with a selectable output tap.
// Optional feature macro: DELAY_CTRL_DROP_CNT_EN (exports the count of valid stages).
module delay_ctrl_line
  import delay_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clr_valid,
  input  logic [DLY_W-1:0] tap,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
`ifdef DELAY_CTRL_DROP_CNT_EN
  ,
  output logic [4:0]       valid_cnt
`endif
);

  logic [WIDTH:0] stage_q [MAX_DELAY];
  logic [WIDTH:0] stage_d [MAX_DELAY];

  // A clear kills every valid bit, including the one entering this edge; data keeps moving.
  always_comb begin
    stage_d[0] = {in_valid & ~clr_valid, in_data};
    for (int i = 1; i < MAX_DELAY; i++) begin
      stage_d[i] = {stage_q[i-1][WIDTH] & ~clr_valid, stage_q[i-1][WIDTH-1:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_DELAY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MAX_DELAY; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign out_valid = stage_q[tap][WIDTH];
  assign out_data  = stage_q[tap][WIDTH-1:0];

`ifdef DELAY_CTRL_DROP_CNT_EN
  logic [MAX_DELAY-1:0] valid_vec;

  always_comb begin
    valid_vec = '0;
    for (int i = 0; i < MAX_DELAY; i++) begin
      valid_vec[i] = stage_q[i][WIDTH];
    end
  end

  assign valid_cnt = count_valid(valid_vec);
`endif

endmodule

// File: rtl/delay_ctrl.sv
// Programmable 1..16 clock sample delay with flush-on-reconfigure control FSM.
// Optional feature macro: DELAY_CTRL_DROP_CNT_EN (adds drop_count output).
module delay_ctrl
  import delay_ctrl_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int RESET_DELAY = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_wr,
  input  logic [DLY_W-1:0] cfg_delay,
  input  logic             validIn,
  input  logic [WIDTH-1:0] dataIn,
  output logic             validOut,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic [DLY_W-1:0] cur_delay,
  output state_t           dbg_state
`ifdef DELAY_CTRL_DROP_CNT_EN
  ,
  output logic [15:0]      drop_count
`endif
);

  localparam logic [DLY_W-1:0] RST_DLY = DLY_W'(RESET_DELAY - 1);

  state_t           state_q, state_d;
  logic [DLY_W:0]   cnt_q, cnt_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic             accept;

  assign accept = validIn & enable;

  // cfg_wr overrides every state; FLUSH lasts cfg_delay+1 clocks counted down to zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dly_d   = dly_q;
    if (cfg_wr) begin
      dly_d   = cfg_delay;
      cnt_d   = {1'b0, cfg_delay} + 5'd1;
      state_d = FLUSH;
    end else begin
      case (state_q)
        IDLE: if (enable) state_d = RUN;
        RUN:  if (!enable) state_d = IDLE;
        FLUSH: begin
          cnt_d = (cnt_q != '0) ? cnt_q - 5'd1 : '0;
          if (cnt_q <= 5'd1) state_d = enable ? RUN : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dly_q   <= RST_DLY;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
    end
  end

  assign busy      = (state_q == FLUSH);
  assign cur_delay = dly_q;
  assign dbg_state = state_q;

`ifdef DELAY_CTRL_DROP_CNT_EN
  logic [4:0]  line_cnt;
  logic [15:0] drop_q, drop_d;
  logic [16:0] drop_sum;

  always_comb begin
    drop_sum = {1'b0, drop_q} + 17'(line_cnt) + 17'(accept);
    drop_d   = drop_q;
    if (cfg_wr) drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) drop_q <= '0;
    else        drop_q <= drop_d;
  end

  assign drop_count = drop_q;
`endif

  delay_ctrl_line #(
    .WIDTH(WIDTH)
  ) u_line (
    .clk       (clock),
    .rst_n     (reset),
    .in_valid  (accept),
    .in_data   (dataIn),
    .clr_valid (cfg_wr),
    .tap       (dly_q),
    .out_valid (validOut),
    .out_data  (dataOut)
`ifdef DELAY_CTRL_DROP_CNT_EN
    ,
    .valid_cnt (line_cnt)
`endif
  );

endmodule

// File: doc/delay_ctrl.md
DELAY_CTRL -- requirements
Module: delay_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, sample data width in bits.
REQ-002 Parameter RESET_DELAY, default 3, delay in clocks loaded at reset; legal range 1..16.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  1 = accept samples; 0 = validIn masked to 0 at chain input.
REQ-006 cfg_wr  input  1  one-cycle strobe; loads cfg_delay as the new delay.
REQ-007 cfg_delay  input  4  new delay minus one, so 0..15 selects 1..16 clocks.
REQ-008 validIn  input  1  sample qualifier.
REQ-009 dataIn  input  WIDTH  sample data.
REQ-010 validOut  output  1  delayed qualifier.
REQ-011 dataOut  output  WIDTH  delayed data.
REQ-012 busy  output  1  high while FLUSH is active.
REQ-013 cur_delay  output  4  active delay minus one.

Function
REQ-014 Shall hold a 16-stage shift chain of {valid, data} that shifts every clock and is never stalled.
REQ-015 validOut/dataOut shall be the chain tap at index cur_delay, so a sample at edge k appears right after edge k+cur_delay; latency is exactly cur_delay+1 clocks.
REQ-016 The chain input valid bit shall be validIn AND enable; data enters unmasked.
REQ-017 FSM states: IDLE (enable=0), FLUSH, RUN.
REQ-018 IDLE->RUN when enable=1 and the FSM is not flushing; RUN->IDLE when enable=0; the chain keeps shifting in IDLE so in-flight samples drain out with correct latency.
REQ-019 On cfg_wr in any state, cur_delay<=cfg_delay, every valid bit in the chain shall clear on that edge, the flush counter shall load cfg_delay+1, and the FSM shall enter FLUSH.
REQ-020 A validIn sample coincident with cfg_wr shall be dropped and shall not appear at validOut.
REQ-021 In FLUSH the counter shall decrement each clock; at zero the FSM shall go to RUN if enable=1, else IDLE.
REQ-022 Samples accepted during FLUSH (after the cfg_wr edge) shall pass normally with the new latency.
REQ-023 A cfg_wr during FLUSH shall restart the flush with the new value. The restart repeats REQ-019.
REQ-024 busy shall be 1 exactly in FLUSH, which lasts cur_delay+1 clocks after the cfg_wr edge.
REQ-025 Every valid sample shall appear at validOut exactly once or be dropped; no duplication when the delay lengthens and no silent loss when it shortens.

Reset
REQ-026 Asserting reset shall immediately clear all chain valid and data bits.
REQ-027 Asserting reset shall set cur_delay=RESET_DELAY-1, zero the flush counter and set state IDLE.
REQ-028 Output values while reset is asserted: validOut=0, dataOut=0, busy=0, cur_delay=RESET_DELAY-1.
REQ-029 Reset asserted mid-FLUSH or mid-stream shall discard all in-flight samples, with no output after release until new input arrives.

Configuration
REQ-030 With DELAY_CTRL_DROP_CNT_EN defined, the block shall add output drop_count [15:0], reset to 0.
REQ-031 drop_count shall increase by the number of valid bits cleared under REQ-019, plus 1 if the coincident validIn&enable was set, saturating at 16'hFFFF.
REQ-032 Without DELAY_CTRL_DROP_CNT_EN, the port and the counting logic shall not exist, and all other behaviour shall be identical.

Structure
REQ-033 Package delay_ctrl_pkg shall hold MAX_DELAY=16, DLY_W=4 and the FSM state type {IDLE, FLUSH, RUN}.
REQ-034 The addressable chain shall be sub-module delay_ctrl_line, which has WIDTH+1 bits per stage, a valid-clear input and a tap address input.
REQ-035 The FSM, the flush counter and the drop counter shall reside in delay_ctrl.

Verification
REQ-036 Reset delay: after reset, enable=1, one sample 0xA5A5A5A5 -> validOut high exactly 3 clocks later with dataOut=0xA5A5A5A5.
REQ-037 Delay extremes: cfg_delay=0 then 15, one-hot samples -> latency exactly 1 and then 16 clocks, busy high 1 and then 16 clocks.
REQ-038 Shorten in flight: delay 16, 10 valid samples sent, cfg_wr cfg_delay=1 on the next sample -> no output from the old samples, post-flush samples at 2 clocks, drop_count=11 when the macro is defined.
REQ-039 Lengthen and restart: cfg_wr 3->12 in RUN, then a second cfg_wr to 5 two cycles later -> busy high continuously for 2+6 clocks, no duplicated output, latency 6.
REQ-040 Enable gating: enable=0 for 5 cycles while validIn=1 -> no validOut for those cycles, earlier samples still exit on time, state IDLE.
REQ-041 Async reset mid-FLUSH: reset pulse asserted between edges -> validOut=0 and busy=0 immediately, cur_delay=2 after release.
